pulse_deser: RTL and testbench
==============================

Name: pulse_deser

Overview:
- Upstream capture stage for the frequency/duty measurement and 7-segment display block.
- Samples one asynchronous pulse input at a programmable rate and packs 32 consecutive samples into a word.
- Presents each word on dsq together with a word clock pclk. The downstream block latches dsq on the falling edge of pclk.
- Also flags a stalled (edge-free) input so the display can blank or hold.

Parameters:
- DIV, 1, system clocks per sample (1..1024); sample strobe fires every DIV clk cycles.
- IDLE_WORDS, 64, number of consecutive edge-free words after which idle asserts (1..65535).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset, deassertion synchronous to clk externally.
- sig_in  input  1  asynchronous pulse input under measurement.
- dsq  output  32  packed sample word; bit0 = oldest sample, bit31 = newest.
- pclk  output  1  word clock; dsq is stable across its falling edge.
- word_vld  output  1  one-clk pulse when dsq updates.
- idle  output  1  high while no edge seen for IDLE_WORDS words.

Behaviour:
- Synchronizer: 2-FF chain on sig_in → s_sync; no logic between the two flops.
- Sample strobe: 10-bit counter divcnt counts 0..DIV-1 and wraps; stb=1 when divcnt==DIV-1. For DIV=1, stb is high every cycle.
- Shift register: on stb, sh <= {s_sync, sh[31:1]}; newest sample enters bit31.
- Bit counter: 5-bit bitcnt increments on each stb, wrapping 31→0.
- Word update: on the stb where bitcnt==31, dsq <= {s_sync, sh[31:1]} (the complete word, including the current sample). word_vld pulses high for exactly that clk.
- Word period: 32·DIV clks. Latency from a sig_in transition to its appearance in dsq ≤ 2 + 32·DIV clks.
- pclk: pclk = ~bitcnt[4], registered.
  - Rises together with the word update (bitcnt 31→0).
  - Falls when bitcnt 15→16, mid-word, so a falling-edge consumer sees a word stable for ≥16·DIV clks on either side.
- Continuity: the previous word's bit31 and the next word's bit0 are consecutive samples. No sample is dropped or duplicated across the word boundary.
- Edge detect per word: last_b holds the previous word's bit31. A word contains an edge if (dsq_next ^ {dsq_next[30:0], last_b}) != 0, evaluated on the word update.
- Idle counter: 16-bit idlecnt.
  - Cleared to 0 on a word containing an edge.
  - Otherwise incremented, saturating at IDLE_WORDS.
  - idle = (idlecnt == IDLE_WORDS), registered; it changes only on word updates.
- Reset values: dsq=0, sh=0, sync FFs=0, last_b=0, divcnt=0, bitcnt=0, pclk=1, word_vld=0, idlecnt=0, idle=0.
- Reset mid-word: partial word is discarded. After release, the first word_vld occurs 32·DIV clks later.
- A constant-high input after reset produces an edge in the first word (last_b=0). This is intended.
- sig_in pulses shorter than DIV clks may be missed. No capture-between-strobes is required.

Optional Feature:
- Macro: PULSE_DESER_GLITCH_FILT_EN.
- Defined:
  - A 3-tap majority filter clocked on stb follows the synchronizer; the filter output replaces s_sync in the shifter.
  - Adds 2 samples of latency.
  - A single-sample glitch (1 sample differing from both neighbours) never reaches dsq.
  - Filter taps reset to 0.
- Undefined: s_sync feeds the shifter directly; no extra latency.

Test Plan:
- Reset/idle line: DIV=1, sig_in=0 for 40·32 clks → dsq=32'h0 every word; word_vld every 32 clks; idle=1 on the 64th word_vld with IDLE_WORDS=64, not before.
- Square wave: DIV=1, sig_in toggling every 8 clks → each dsq ∈ {32'h00FF00FF, 32'hFF00FF00} rotated by a constant phase; all words identical in steady state; idle stays 0.
- Boundary continuity: DIV=2, single high pulse of 2 clks placed to straddle a word boundary → one sample shows as 1: bit31 of word N or bit0 of word N+1, never both and never neither.
- pclk timing: DIV=3 → pclk high 48 clks, low 48 clks; dsq changes only in the clk where pclk rises; word_vld coincident with that rise.
- Async reset mid-word: assert rst_n low at bitcnt=17 → all outputs at reset values immediately without a clk edge; after release, first word_vld at 32·DIV clks.
- Glitch filter (macro defined): DIV=1, sig_in=0 with one 1-clk high pulse → dsq stays 0; same test with macro undefined → exactly one bit set in one word.

Source files
------------

// File: rtl/pulse_deser.sv
`timescale 1ns/1ps
// Purpose : sample an asynchronous pulse input every DIV clks and pack 32 samples per word.
// Latency : a sig_in transition reaches dsq within 2 + 32*DIV clks (2 more samples with the filter).
// Backpressure: none; free-running producer, the consumer latches dsq on the falling edge of pclk.
//
// Build option: `define PULSE_DESER_GLITCH_FILT_EN inserts a 3-tap majority filter,
// clocked on the sample strobe, between the synchronizer and the shift register.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   sig_in    asynchronous pulse input under measurement
//   dsq       packed sample word, bit0 = oldest sample, bit31 = newest
//   pclk      word clock; rises with each word update, falls mid-word
//   word_vld  one-clk pulse in the cycle dsq takes a new word
//   idle      high once IDLE_WORDS consecutive words contained no edge
module pulse_deser #(
  parameter int DIV        = 1,
  parameter int IDLE_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  output logic [31:0] dsq,
  output logic        pclk,
  output logic        word_vld,
  output logic        idle
);

  localparam logic [9:0]  DIV_LAST = 10'(DIV - 1);
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_WORDS);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer, nothing between the stages.
  // ---------------------------------------------------------------------------
  logic sync_q;
  logic s_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      sync_q <= sig_in;
      s_sync <= sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample strobe: one clk in every DIV; with DIV=1 it is permanently high.
  // ---------------------------------------------------------------------------
  logic [9:0] divcnt;
  logic       stb;

  assign stb = (divcnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divcnt <= '0;
    end else if (stb) begin
      divcnt <= '0;
    end else begin
      divcnt <= divcnt + 10'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample source for the shifter.
  // ---------------------------------------------------------------------------
  logic samp;

`ifdef PULSE_DESER_GLITCH_FILT_EN
  // Three registered taps; the majority is centred on the sample taken two
  // strobes ago, so an isolated one-sample glitch is always outvoted.
  logic [2:0] taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (stb) begin
      taps <= {taps[1:0], s_sync};
    end
  end

  assign samp = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
`else
  assign samp = s_sync;
`endif

  // ---------------------------------------------------------------------------
  // Shift register and bit counter.
  // The oldest sample would be shifted straight out without ever being read,
  // so only bits 31..1 are stored; word_next is the full 32-sample word.
  // ---------------------------------------------------------------------------
  logic [31:1] sh;
  logic [31:0] word_next;
  logic [4:0]  bitcnt;
  logic [4:0]  bitcnt_next;
  logic        word_end;

  assign word_next   = {samp, sh[31:1]};
  assign bitcnt_next = bitcnt + 5'd1;
  assign word_end    = stb && (bitcnt == 5'd31);

  // pclk tracks ~bitcnt[4] as a register: it rises on the 31->0 wrap together
  // with the word update and falls on 15->16, half a word later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh     <= '0;
      bitcnt <= '0;
      pclk   <= 1'b1;
    end else if (stb) begin
      sh     <= word_next[31:1];
      bitcnt <= bitcnt_next;
      pclk   <= ~bitcnt_next[4];
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection and idle tracking, evaluated once per word.
  // The word is compared against itself shifted by one sample, with the
  // previous word's newest sample filling in below bit0, so an edge exactly
  // on the word boundary is also caught.
  // ---------------------------------------------------------------------------
  logic        last_b;
  logic        has_edge;
  logic [15:0] idlecnt;
  logic [15:0] idlecnt_next;

  assign has_edge = |(word_next ^ {word_next[30:0], last_b});

  always_comb begin
    idlecnt_next = idlecnt;
    if (has_edge) begin
      idlecnt_next = '0;
    end else if (idlecnt != IDLE_MAX) begin
      idlecnt_next = idlecnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsq      <= '0;
      word_vld <= 1'b0;
      last_b   <= 1'b0;
      idlecnt  <= '0;
      idle     <= 1'b0;
    end else begin
      word_vld <= word_end;
      if (word_end) begin
        dsq     <= word_next;
        last_b  <= word_next[31];
        idlecnt <= idlecnt_next;
        idle    <= (idlecnt_next == IDLE_MAX);
      end
    end
  end

endmodule

// File: tb/tb_pulse_deser.sv
`timescale 1ns/1ps
module tb_pulse_deser;

  localparam int NI = 3;            // instances with DIV = 1, 2, 3
  localparam int IW = 64;

`ifdef PULSE_DESER_GLITCH_FILT_EN
  localparam int GLITCH_ONES = 0;
`else
  localparam int GLITCH_ONES = 1;
`endif

  logic          clk = 1'b0;
  logic [NI-1:0] rstn;
  logic [NI-1:0] sig;
  logic [31:0]   dsq_w  [NI];
  logic          pclk_w [NI];
  logic          vld_w  [NI];
  logic          idle_w [NI];

  pulse_deser #(.DIV(1), .IDLE_WORDS(IW)) u_div1 (
    .clk(clk), .rst_n(rstn[0]), .sig_in(sig[0]), .dsq(dsq_w[0]),
    .pclk(pclk_w[0]), .word_vld(vld_w[0]), .idle(idle_w[0]));
  pulse_deser #(.DIV(2), .IDLE_WORDS(IW)) u_div2 (
    .clk(clk), .rst_n(rstn[1]), .sig_in(sig[1]), .dsq(dsq_w[1]),
    .pclk(pclk_w[1]), .word_vld(vld_w[1]), .idle(idle_w[1]));
  pulse_deser #(.DIV(3), .IDLE_WORDS(IW)) u_div3 (
    .clk(clk), .rst_n(rstn[2]), .sig_in(sig[2]), .dsq(dsq_w[2]),
    .pclk(pclk_w[2]), .word_vld(vld_w[2]), .idle(idle_w[2]));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model of the active instance: 2-clk synchronizer delay, one
  // sample every DIV edges after reset release, 32 samples per word, per-word
  // edge/idle tracking. Completed words go to the scoreboard queue.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] w;
    logic        idle;
  } exp_t;

  exp_t        q[$];
  int          cur = 0;
  int          ecnt, nb, midc;
  logic        p1, p2, mlast;
  logic [31:0] wacc;
  logic        samp, fed, chg;
  exp_t        e_push;
`ifdef PULSE_DESER_GLITCH_FILT_EN
  logic        r1, r2, r3;
`endif

  always @(posedge clk) begin
    if (!rstn[cur]) begin
      ecnt = 0; nb = 0; midc = 0; p1 = 1'b0; p2 = 1'b0; mlast = 1'b0; wacc = '0;
`ifdef PULSE_DESER_GLITCH_FILT_EN
      r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
`endif
      q.delete();
    end else begin
      ecnt++;
      samp = p2;
      p2   = p1;
      p1   = sig[cur];
      if (ecnt % (cur + 1) == 0) begin
`ifdef PULSE_DESER_GLITCH_FILT_EN
        fed = (r1 & r2) | (r1 & r3) | (r2 & r3);
        r3 = r2; r2 = r1; r1 = samp;
`else
        fed = samp;
`endif
        wacc[nb] = fed;
        if (nb == 31) begin
          chg   = |(wacc ^ {wacc[30:0], mlast});
          mlast = wacc[31];
          if (chg) midc = 0;
          else if (midc < IW) midc++;
          e_push.w    = wacc;
          e_push.idle = (midc == IW);
          q.push_back(e_push);
          nb = 0;
        end else begin
          nb++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor on the falling edge: pops the scoreboard on word_vld, checks pclk
  // phase every cycle and that dsq/idle hold between word updates.
  // ---------------------------------------------------------------------------
  int          wcnt, tot_ones, first_idle;
  logic [31:0] last_w, prev_w, prev_dsq;
  logic        prev_idle;
  exp_t        e_pop;

  always @(negedge clk) begin
    chk("pclk_phase", pclk_w[cur], (nb < 16));
    if (!rstn[cur]) begin
      prev_dsq  = dsq_w[cur];
      prev_idle = idle_w[cur];
    end else if (vld_w[cur]) begin
      chk("word_queued", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e_pop = q.pop_front();
        chk("dsq", dsq_w[cur], e_pop.w);
        chk("idle", idle_w[cur], e_pop.idle);
      end
      wcnt++;
      tot_ones += $countones(dsq_w[cur]);
      prev_w = last_w;
      last_w = dsq_w[cur];
      if (idle_w[cur] && first_idle == 0) first_idle = wcnt;
      prev_dsq  = dsq_w[cur];
      prev_idle = idle_w[cur];
    end else begin
      chk("word_late", q.size(), 0);
      chk("dsq_hold", dsq_w[cur], prev_dsq);
      chk("idle_hold", idle_w[cur], prev_idle);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus table.
  // ---------------------------------------------------------------------------
  localparam int M_CONST = 0, M_SQUARE = 1, M_PULSE = 2;

  typedef struct {
    int   sel;            // instance: DIV = sel+1
    int   mode;
    int   a;              // level / half period / pulse start edge
    int   b;              // pulse width in clks
    int   nw;             // words to run
    logic exp_idle;       // idle after the last word
    int   exp_first_idle; // word index where idle first rose, 0 = never
    int   exp_last_pop;   // popcount of last word, -1 = not checked
    int   exp_tot;        // total ones over all words, -1 = not checked
    bit   steady;         // last word equals the one before it
  } vec_t;

  vec_t tbl[8];

  function automatic logic pat(input vec_t v, input int k);
    case (v.mode)
      M_CONST:  return (v.a != 0);
      M_SQUARE: return (((k - 1) / v.a) % 2) == 1;
      default:  return (k >= v.a) && (k < v.a + v.b);
    endcase
  endfunction

  task automatic do_reset(input int sel);
    @(negedge clk); #2;
    rstn = '0;
    sig  = '0;
    cur  = sel;
    wcnt = 0; tot_ones = 0; first_idle = 0; last_w = '0; prev_w = '0;
    repeat (3) @(negedge clk);
    #2 rstn[sel] = 1'b1;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int n_edges;
    n_edges = v.nw * 32 * (v.sel + 1);
    do_reset(v.sel);
    sig[v.sel] = pat(v, 1);
    for (int k = 2; k <= n_edges; k++) begin
      @(negedge clk);
      sig[v.sel] = pat(v, k);
    end
    @(negedge clk); #2;
    chk($sformatf("c%0d_words", idx), wcnt, v.nw);
    chk($sformatf("c%0d_idle_end", idx), idle_w[v.sel], v.exp_idle);
    chk($sformatf("c%0d_first_idle", idx), first_idle, v.exp_first_idle);
    if (v.exp_last_pop >= 0) chk($sformatf("c%0d_last_pop", idx), $countones(last_w), v.exp_last_pop);
    if (v.exp_tot >= 0)      chk($sformatf("c%0d_tot_ones", idx), tot_ones, v.exp_tot);
    if (v.steady)            chk($sformatf("c%0d_steady", idx), last_w, prev_w);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, hi, lo;
    logic found, pp;

    //         sel mode      a   b  nw  idle first lpop tot          steady
    tbl[0] = '{0, M_CONST,   0,  0, 70, 1'b1, 64,  0,   0,           1'b1};
    tbl[1] = '{0, M_SQUARE,  8,  0,  6, 1'b0,  0, 16,  -1,           1'b1};
    tbl[2] = '{1, M_SQUARE,  4,  0,  5, 1'b0,  0, 16,  -1,           1'b1};
    tbl[3] = '{1, M_PULSE,  62,  2,  3, 1'b0,  0, -1,  GLITCH_ONES,  1'b0};
    tbl[4] = '{1, M_PULSE,  63,  2,  3, 1'b0,  0, -1,  GLITCH_ONES,  1'b0};
    tbl[5] = '{0, M_PULSE,  40,  1,  3, 1'b0,  0, -1,  GLITCH_ONES,  1'b0};
    tbl[6] = '{2, M_SQUARE, 24,  0,  4, 1'b0,  0, 16,  -1,           1'b1};
    tbl[7] = '{0, M_CONST,   1,  0, 70, 1'b1, 65, 32,  -1,           1'b1};

    // Power-on reset: an explicit falling edge on rst_n.
    rstn = '1;
    sig  = '0;
    #1 rstn = '0;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_dsq%0d", i), dsq_w[i], 32'h0);
      chk($sformatf("rst_pclk%0d", i), pclk_w[i], 1);
      chk($sformatf("rst_vld%0d", i), vld_w[i], 0);
      chk($sformatf("rst_idle%0d", i), idle_w[i], 0);
    end

    for (int i = 0; i < 7; i++) begin
      run_case(tbl[i], i);
      if (i == 6) begin
        // pclk duty on DIV=3: 48 clks high, 48 low, word_vld on the rise.
        found = 1'b0;
        pp    = pclk_w[2];
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (pclk_w[2] && !pp) begin
            found = 1'b1;
            break;
          end
          pp = pclk_w[2];
        end
        chk("pclk_rise_found", found, 1);
        chk("vld_at_pclk_rise", vld_w[2], 1);
        hi = 1;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (!pclk_w[2]) break;
          hi++;
        end
        lo = 1;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (pclk_w[2]) break;
          lo++;
        end
        chk("pclk_high_clks", hi, 48);
        chk("pclk_low_clks", lo, 48);
      end
    end

    // Constant high on DIV=1, then an asynchronous reset at bitcnt=17.
    run_case(tbl[7], 7);
    repeat (17) begin
      @(negedge clk);
      sig[0] = 1'b1;
    end
    #2;
    chk("pre_rst_pclk", pclk_w[0], 0);
    chk("pre_rst_idle", idle_w[0], 1);
    chk("pre_rst_dsq", dsq_w[0], 32'hFFFF_FFFF);
    rstn[0] = 1'b0;
    #1;
    chk("arst_dsq", dsq_w[0], 32'h0);
    chk("arst_pclk", pclk_w[0], 1);
    chk("arst_vld", vld_w[0], 0);
    chk("arst_idle", idle_w[0], 0);
    repeat (2) @(negedge clk);
    #2 rstn[0] = 1'b1;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (vld_w[0] && got == 0) got = k;
    end
    chk("first_vld_after_arst", got, 32);

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
